robot_sensor_frontend: RTL and testbench

//  Upstream stage of pipeFSM: synchronises raw wall/compass/maintenance sensors, debounces wall

---
 rtl/robot_sensor_frontend_pkg.sv | 14 +
 rtl/robot_sensor_frontend_sync.sv | 20 ++
 rtl/robot_sensor_frontend.sv | 137 +++++++++++++
 tb/tb_robot_sensor_frontend.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/robot_sensor_frontend_pkg.sv
// robot_sensor_frontend_pkg: FSM state encoding, compass codes and sensor encoding checks.
package robot_sensor_frontend_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD, WAIT_CLR} state_t;
  localparam logic [3:0] CMPS_N = 4'b1000;
  localparam logic [3:0] CMPS_E = 4'b0100;
  localparam logic [3:0] CMPS_S = 4'b0010;
  localparam logic [3:0] CMPS_W = 4'b0001;
  function automatic logic is_onehot(input logic [3:0] v);
    return v inside {CMPS_N, CMPS_E, CMPS_S, CMPS_W};
  endfunction
  function automatic logic is_zero_or_onehot(input logic [3:0] v);
    return (v == 4'b0000) || is_onehot(v);
  endfunction
endpackage

// File: rtl/robot_sensor_frontend_sync.sv
// sensor_sync: W-bit two-flop synchroniser for asynchronous sensor inputs.
module sensor_sync #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta, r_sync;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  assign o_q = r_sync;
endmodule

// File: rtl/robot_sensor_frontend.sv
// robot_sensor_frontend: synchronise, debounce and validate sensors; one frame per wall event.
// Define SENSOR_FE_TIMEOUT_EN to drop frames left unaccepted for TIMEOUT_CYCLES.
module robot_sensor_frontend
  import robot_sensor_frontend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int OVR_W           = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [2:0]       i_wll_raw,
  input  logic [3:0]       i_cmps_raw,
  input  logic [3:0]       i_mtn_raw,
  input  logic             i_clr_err,
  input  logic             i_frame_ready,
  output logic             o_frame_valid,
  output logic [2:0]       o_wll,
  output logic [3:0]       o_cmps,
  output logic [3:0]       o_mtn_sensor,
  output logic             o_err_cmps,
  output logic             o_err_mtn,
  output logic [OVR_W-1:0] o_ovr_cnt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB = CW'(DEBOUNCE_CYCLES);
  logic [10:0]      w_s;
  logic [2:0]       w_s_wll;
  logic [3:0]       w_s_cmps, w_s_mtn;
  logic             w_nz;
  state_t           r_state, w_state;
  logic [CW-1:0]    r_cnt, w_cnt, w_run;
  logic [2:0]       r_last, w_last;
  logic             r_prev_nz;
  logic             r_valid, w_valid;
  logic [2:0]       r_wll, w_wll;
  logic [3:0]       r_cmps, w_cmps, r_mtn, w_mtn;
  logic             r_err_c, r_err_m, w_set_c, w_set_m, w_ovr_ev;
  logic [OVR_W-1:0] r_ovr;
  sensor_sync #(.W(11)) u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    ({i_wll_raw, i_cmps_raw, i_mtn_raw}),
    .o_q    (w_s)
  );
  assign {w_s_wll, w_s_cmps, w_s_mtn} = w_s;
  assign w_nz = |w_s_wll;
`ifdef SENSOR_FE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_wait;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_wait <= '0;
    else r_wait <= (r_state == HOLD && !i_frame_ready) ? r_wait + 1'b1 : '0;
`endif
  // IDLE and SETTLE share one run-length count so a single stable sample suffices when DB is 1
  assign w_run = (r_state == SETTLE && w_s_wll == r_last) ? r_cnt + 1'b1 : CW'(1);
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_last   = r_last;
    w_valid  = r_valid;
    w_wll    = r_wll;
    w_cmps   = r_cmps;
    w_mtn    = r_mtn;
    w_set_c  = 1'b0;
    w_set_m  = 1'b0;
    w_ovr_ev = 1'b0;
    case (r_state)
      IDLE, SETTLE:
        if (!w_nz) w_state = IDLE;
        else if (w_run >= DB) begin
          w_wll   = w_s_wll;
          w_cmps  = w_s_cmps;
          w_mtn   = is_zero_or_onehot(w_s_mtn) ? w_s_mtn : 4'b0000;
          w_set_c = !is_onehot(w_s_cmps);
          w_set_m = !is_zero_or_onehot(w_s_mtn);
          w_valid = is_onehot(w_s_cmps);
          w_state = is_onehot(w_s_cmps) ? HOLD : WAIT_CLR;
        end else begin
          w_state = SETTLE;
          w_cnt   = w_run;
          w_last  = w_s_wll;
        end
      HOLD: begin
        w_ovr_ev = w_nz && !r_prev_nz;
        if (i_frame_ready) begin
          w_valid = 1'b0;
          w_state = WAIT_CLR;
        end
`ifdef SENSOR_FE_TIMEOUT_EN
        else if (r_wait == TO_LAST) begin
          w_valid  = 1'b0;
          w_ovr_ev = 1'b1;
          w_state  = WAIT_CLR;
        end
`endif
      end
      WAIT_CLR: w_state = w_nz ? WAIT_CLR : IDLE;
      default:  w_state = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_last    <= '0;
      r_prev_nz <= 1'b0;
      r_valid   <= 1'b0;
      r_wll     <= '0;
      r_cmps    <= '0;
      r_mtn     <= '0;
      r_err_c   <= 1'b0;
      r_err_m   <= 1'b0;
      r_ovr     <= '0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_last    <= w_last;
      r_prev_nz <= w_nz;
      r_valid   <= w_valid;
      r_wll     <= w_wll;
      r_cmps    <= w_cmps;
      r_mtn     <= w_mtn;
      r_err_c   <= w_set_c | (r_err_c & ~i_clr_err);
      r_err_m   <= w_set_m | (r_err_m & ~i_clr_err);
      r_ovr     <= w_ovr_ev ? (i_clr_err ? OVR_W'(1) : (&r_ovr ? r_ovr : r_ovr + 1'b1))
                            : (i_clr_err ? '0 : r_ovr);
    end
  assign o_frame_valid = r_valid;
  assign o_wll         = r_wll;
  assign o_cmps        = r_cmps;
  assign o_mtn_sensor  = r_mtn;
  assign o_err_cmps    = r_err_c;
  assign o_err_mtn     = r_err_m;
  assign o_ovr_cnt     = r_ovr;
endmodule

// File: tb/tb_robot_sensor_frontend.sv
// tb_robot_sensor_frontend: random and directed stimulus against a behavioural frame model.
module tb_robot_sensor_frontend;
  localparam int DEB = 2;
  localparam int OVR_MAX = 15;
  localparam int TO = 64;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] wll_raw = 3'b111;
  logic [3:0] cmps_raw = 4'b1000, mtn_raw = 4'b0001;
  logic       clr_err = 1'b0, frame_ready = 1'b0;
  logic       o_frame_valid, o_err_cmps, o_err_mtn;
  logic [2:0] o_wll;
  logic [3:0] o_cmps, o_mtn_sensor, o_ovr_cnt;
  int n_chk = 0, n_fail = 0;
  logic [10:0] hist[$];
  int m_valid, m_wll, m_cmps, m_mtn, m_ec, m_em, m_ovr, m_mode, m_run, m_last, m_prev_nz, m_age;
  robot_sensor_frontend dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wll_raw(wll_raw), .i_cmps_raw(cmps_raw),
    .i_mtn_raw(mtn_raw), .i_clr_err(clr_err), .i_frame_ready(frame_ready),
    .o_frame_valid(o_frame_valid), .o_wll(o_wll), .o_cmps(o_cmps),
    .o_mtn_sensor(o_mtn_sensor), .o_err_cmps(o_err_cmps), .o_err_mtn(o_err_mtn),
    .o_ovr_cnt(o_ovr_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    hist = '{11'd0, 11'd0};
    {m_valid, m_wll, m_cmps, m_mtn, m_ec, m_em, m_ovr} = '0;
    {m_mode, m_run, m_last, m_prev_nz, m_age} = '0;
  endtask
  // mode: 0 seeking a stable wall, 1 frame pending, 2 waiting for the wall to clear
  task automatic model_edge();
    logic [10:0] s;
    int sw, sc, sm, new_ec, new_em, ovr_ev;
    s = hist.pop_front();
    hist.push_back({wll_raw, cmps_raw, mtn_raw});
    sw = int'(s[10:8]); sc = int'(s[7:4]); sm = int'(s[3:0]);
    new_ec = 0; new_em = 0; ovr_ev = 0;
    if (m_mode == 1) begin
      if (sw != 0 && m_prev_nz == 0) ovr_ev = 1;
      m_age++;
      if (frame_ready) begin m_valid = 0; m_mode = 2; end
`ifdef SENSOR_FE_TIMEOUT_EN
      else if (m_age == TO) begin m_valid = 0; m_mode = 2; ovr_ev = 1; end
`endif
    end else if (m_mode == 2) begin
      if (sw == 0) begin m_mode = 0; m_run = 0; end
    end else begin
      m_run = (sw == 0) ? 0 : (sw == m_last && m_run > 0) ? m_run + 1 : 1;
      m_last = sw;
      if (m_run == DEB) begin
        m_wll = sw; m_cmps = sc;
        m_mtn = ($countones(s[3:0]) <= 1) ? sm : 0;
        new_em = ($countones(s[3:0]) > 1) ? 1 : 0;
        new_ec = ($countones(s[7:4]) != 1) ? 1 : 0;
        m_valid = new_ec ? 0 : 1;
        m_mode = new_ec ? 2 : 1;
        m_age = 0;
      end
    end
    m_prev_nz = (sw != 0) ? 1 : 0;
    m_ec = (new_ec || (m_ec && !clr_err)) ? 1 : 0;
    m_em = (new_em || (m_em && !clr_err)) ? 1 : 0;
    if (ovr_ev) m_ovr = clr_err ? 1 : (m_ovr < OVR_MAX ? m_ovr + 1 : OVR_MAX);
    else if (clr_err) m_ovr = 0;
  endtask
  task automatic compare_all(input string ph);
    chk({ph, ".valid"}, 32'(o_frame_valid), m_valid);
    chk({ph, ".wll"}, 32'(o_wll), m_wll);
    chk({ph, ".cmps"}, 32'(o_cmps), m_cmps);
    chk({ph, ".mtn"}, 32'(o_mtn_sensor), m_mtn);
    chk({ph, ".err_cmps"}, 32'(o_err_cmps), m_ec);
    chk({ph, ".err_mtn"}, 32'(o_err_mtn), m_em);
    chk({ph, ".ovr"}, 32'(o_ovr_cnt), m_ovr);
  endtask
  task automatic cyc(input logic [2:0] w, input logic [3:0] c, input logic [3:0] m,
                     input logic rdy, input logic clr, input string ph);
    wll_raw = w; cmps_raw = c; mtn_raw = m; frame_ready = rdy; clr_err = clr;
    @(posedge clk);
    model_edge();
    #1 compare_all(ph);
  endtask
  initial begin
    logic [2:0] w;
    logic [3:0] c, m;
    int len, rp;
    model_reset();
    #22 compare_all("reset");
    #5 rst_n = 1'b1;
    repeat (3) cyc(3'b000, 4'b1000, 4'b0000, 1'b1, 1'b0, "idle");
    repeat (3) cyc(3'b110, 4'b1000, 4'b0001, 1'b1, 1'b0, "basic");
    repeat (6) cyc(3'b000, 4'b1000, 4'b0001, 1'b1, 1'b0, "basic");
    cyc(3'b101, 4'b0100, 4'b0000, 1'b1, 1'b0, "glitch");
    repeat (5) cyc(3'b000, 4'b0100, 4'b0000, 1'b1, 1'b0, "glitch");
    repeat (4) cyc(3'b011, 4'b1100, 4'b0000, 1'b1, 1'b0, "badcmps");
    repeat (4) cyc(3'b000, 4'b0010, 4'b0011, 1'b1, 1'b0, "badcmps");
    repeat (4) cyc(3'b001, 4'b0010, 4'b0011, 1'b1, 1'b0, "badmtn");
    repeat (4) cyc(3'b000, 4'b0010, 4'b0000, 1'b1, 1'b0, "badmtn");
    chk("err_both_set", 32'(o_err_cmps & o_err_mtn), 1);
    cyc(3'b000, 4'b0010, 4'b0000, 1'b1, 1'b1, "clr");
    cyc(3'b000, 4'b0010, 4'b0000, 1'b1, 1'b0, "clr");
    for (int seg = 0; seg < 400; seg++) begin
      len = $urandom_range(1, 6);
      w = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0001 << $urandom_range(0, 3);
      m = ($urandom_range(0, 5) == 0) ? 4'($urandom) :
          ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'b0001 << $urandom_range(0, 3);
      rp = (seg % 40 < 20) ? 70 : 5;
      for (int i = 0; i < len; i++)
        cyc(w, c, m, $urandom_range(0, 99) < rp, $urandom_range(0, 29) == 0, "rand");
    end
    repeat (6) cyc(3'b000, 4'b1000, 4'b0000, 1'b1, 1'b1, "pre_ovr");
    repeat (4) cyc(3'b011, 4'b0100, 4'b0010, 1'b0, 1'b0, "ovr");
    for (int p = 0; p < 20; p++) begin
      repeat (3) cyc(3'b000, 4'b1000, 4'b0001, 1'b0, 1'b0, "ovr");
      repeat (3) cyc(3'b111, 4'b0001, 4'b0100, 1'b0, 1'b0, "ovr");
      if (p == 2) chk("ovr_three", 32'(o_ovr_cnt), 3);
    end
    chk("ovr_saturated", 32'(o_ovr_cnt), OVR_MAX);
`ifndef SENSOR_FE_TIMEOUT_EN
    repeat (80) cyc(3'b000, 4'b1000, 4'b0000, 1'b0, 1'b0, "hold");
    chk("hold_still_valid", 32'(o_frame_valid), 1);
    chk("hold_fields", 32'({o_wll, o_cmps, o_mtn_sensor}), 32'({3'b011, 4'b0100, 4'b0010}));
`endif
    cyc(3'b000, 4'b1000, 4'b0000, 1'b1, 1'b0, "accept");
    cyc(3'b000, 4'b1000, 4'b0000, 1'b1, 1'b0, "accept");
    repeat (5) cyc(3'b010, 4'b0010, 4'b0000, 1'b0, 1'b0, "midrst");
    chk("valid_before_reset", 32'(o_frame_valid), 1);
    #3 rst_n = 1'b0;
    model_reset();
    #1 compare_all("async_reset");
    #2 rst_n = 1'b1;
    repeat (6) cyc(3'b000, 4'b1000, 4'b0000, 1'b1, 1'b0, "post_rst");
    repeat (4) cyc(3'b100, 4'b1000, 4'b0000, 1'b1, 1'b0, "post_rst");
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
